rs_multi_cdb: RTL and testbench

Parametrised out-of-order reservation station for ALU/branch instructions, between the issue stage and the ALU functional unit.
- Holds DEPTH entries and wakes operands from N_CDB result-broadcast channels, ROB and LSB among them.
- Dispatches the oldest ready entry through a valid/ready handshake, so the FU can back-pressure.
- Improves on the previous station with age-ordered select, same-cycle issue wakeup, multi-channel broadcast and explicit dispatch stall.

---
 rtl/rs_multi_cdb_pkg.sv | 17 +
 rtl/rs_age_select.sv | 24 ++
 rtl/rs_multi_cdb.sv | 209 ++++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_multi_cdb_pkg.sv
// Shared defaults and opcode encodings for the ALU/branch reservation station.
package rs_multi_cdb_pkg;
  localparam int RS_SIZE    = 16;
  localparam int RS_N_CDB   = 2;
  localparam int RS_ROB_LOG = 4;
  localparam int RS_OP_LOG  = 6;
  localparam int RS_XLEN    = 32;

  localparam logic [RS_OP_LOG-1:0] OP_ADD = 6'd1;
  localparam logic [RS_OP_LOG-1:0] OP_SUB = 6'd2;
  localparam logic [RS_OP_LOG-1:0] OP_AND = 6'd3;
  localparam logic [RS_OP_LOG-1:0] OP_OR  = 6'd4;
  localparam logic [RS_OP_LOG-1:0] OP_XOR = 6'd5;
  localparam logic [RS_OP_LOG-1:0] OP_BEQ = 6'd16;
  localparam logic [RS_OP_LOG-1:0] OP_BNE = 6'd17;
  localparam logic [RS_OP_LOG-1:0] OP_JAL = 6'd24;
endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: grants the eligible entry with no older eligible entry.
module rs_age_select
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH = RS_SIZE
) (
  input  logic [DEPTH-1:0] eligible,
  input  logic [DEPTH-1:0] older [DEPTH],
  output logic [DEPTH-1:0] grant,
  output logic             grant_valid
);
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
      // Column gi of the matrix: which entries were issued before entry gi.
      logic [DEPTH-1:0] older_than_me;
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
        assign older_than_me[gj] = older[gj][gi];
      end
      assign grant[gi] = eligible[gi] && !(|(older_than_me & eligible));
    end
  endgenerate

  assign grant_valid = |eligible;
endmodule

// File: rtl/rs_multi_cdb.sv
// Out-of-order reservation station: multi-CDB wakeup, age-ordered select, stallable dispatch register.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH   = RS_SIZE,
  parameter int N_CDB   = RS_N_CDB,
  parameter int ROB_LOG = RS_ROB_LOG,
  parameter int OP_LOG  = RS_OP_LOG,
  parameter int XLEN    = RS_XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [OP_LOG-1:0]        issue_op,
  input  logic [XLEN-1:0]          issue_vj,
  input  logic [XLEN-1:0]          issue_vk,
  input  logic                     issue_rj,
  input  logic                     issue_rk,
  input  logic [ROB_LOG-1:0]       issue_qj,
  input  logic [ROB_LOG-1:0]       issue_qk,
  input  logic [XLEN-1:0]          issue_imm,
  input  logic [ROB_LOG-1:0]       issue_dest_rob,
  input  logic [XLEN-1:0]          issue_cur_pc,
  input  logic [N_CDB-1:0]         cdb_valid,
  input  logic [N_CDB*ROB_LOG-1:0] cdb_rob,
  input  logic [N_CDB*XLEN-1:0]    cdb_value,
  output logic                     fu_valid,
  input  logic                     fu_ready,
  output logic [OP_LOG-1:0]        fu_op,
  output logic [XLEN-1:0]          fu_vj,
  output logic [XLEN-1:0]          fu_vk,
  output logic [XLEN-1:0]          fu_imm,
  output logic [ROB_LOG-1:0]       fu_dest_rob,
  output logic [XLEN-1:0]          fu_cur_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]   busy_reg, rj_reg, rk_reg;
  logic [OP_LOG-1:0]  op_reg   [DEPTH];
  logic [XLEN-1:0]    vj_reg   [DEPTH];
  logic [XLEN-1:0]    vk_reg   [DEPTH];
  logic [ROB_LOG-1:0] qj_reg   [DEPTH];
  logic [ROB_LOG-1:0] qk_reg   [DEPTH];
  logic [XLEN-1:0]    imm_reg  [DEPTH];
  logic [ROB_LOG-1:0] dest_reg [DEPTH];
  logic [XLEN-1:0]    pc_reg   [DEPTH];
  logic [DEPTH-1:0]   older_reg[DEPTH];
  logic [CNT_W-1:0]   occ_reg;

  logic               fu_valid_reg;
  logic [OP_LOG-1:0]  fu_op_reg;
  logic [XLEN-1:0]    fu_vj_reg, fu_vk_reg, fu_imm_reg, fu_pc_reg;
  logic [ROB_LOG-1:0] fu_dest_reg;

  logic [DEPTH-1:0]   eligible, grant, free_vec, alloc_onehot;
  logic               grant_valid, fu_free, issue_fire, disp_fire;
  logic               bj_hit, bk_hit;
  logic [XLEN-1:0]    bj_val, bk_val;
  logic [DEPTH-1:0]   wj_hit, wk_hit;
  logic [XLEN-1:0]    wj_val [DEPTH];
  logic [XLEN-1:0]    wk_val [DEPTH];
  logic [OP_LOG-1:0]  sel_op;
  logic [XLEN-1:0]    sel_vj, sel_vk, sel_imm, sel_pc;
  logic [ROB_LOG-1:0] sel_dest;

  assign issue_ready  = (occ_reg < FULL_CNT);
  assign issue_fire   = issue_valid && issue_ready;
  assign free_vec     = ~busy_reg;
  assign alloc_onehot = free_vec & (~free_vec + DEPTH'(1));
  assign eligible     = busy_reg & rj_reg & rk_reg;
  assign fu_free      = !fu_valid_reg || fu_ready;
  assign disp_fire    = fu_free && grant_valid;

  rs_age_select #(.DEPTH(DEPTH)) u_select (
    .eligible    (eligible),
    .older       (older_reg),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Channels scanned high to low so the lowest-index match is the one kept.
  always_comb begin
    bj_hit = 1'b0;
    bk_hit = 1'b0;
    bj_val = '0;
    bk_val = '0;
    wj_hit = '0;
    wk_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wj_val[i] = '0;
      wk_val[i] = '0;
    end
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c]) begin
        if (cdb_rob[c*ROB_LOG +: ROB_LOG] == issue_qj) begin
          bj_hit = 1'b1;
          bj_val = cdb_value[c*XLEN +: XLEN];
        end
        if (cdb_rob[c*ROB_LOG +: ROB_LOG] == issue_qk) begin
          bk_hit = 1'b1;
          bk_val = cdb_value[c*XLEN +: XLEN];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_rob[c*ROB_LOG +: ROB_LOG] == qj_reg[i]) begin
            wj_hit[i] = 1'b1;
            wj_val[i] = cdb_value[c*XLEN +: XLEN];
          end
          if (cdb_rob[c*ROB_LOG +: ROB_LOG] == qk_reg[i]) begin
            wk_hit[i] = 1'b1;
            wk_val[i] = cdb_value[c*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    sel_op   = '0;
    sel_vj   = '0;
    sel_vk   = '0;
    sel_imm  = '0;
    sel_pc   = '0;
    sel_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_op   = op_reg[i];
        sel_vj   = vj_reg[i];
        sel_vk   = vk_reg[i];
        sel_imm  = imm_reg[i];
        sel_pc   = pc_reg[i];
        sel_dest = dest_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg     <= '0;
      occ_reg      <= '0;
      fu_valid_reg <= 1'b0;
      fu_op_reg    <= '0;
      fu_vj_reg    <= '0;
      fu_vk_reg    <= '0;
      fu_imm_reg   <= '0;
      fu_pc_reg    <= '0;
      fu_dest_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else if (flush) begin
      busy_reg     <= '0;
      occ_reg      <= '0;
      fu_valid_reg <= 1'b0;
    end else if (rdy) begin
      occ_reg <= occ_reg + CNT_W'(issue_fire) - CNT_W'(disp_fire);
      if (fu_free) begin
        fu_valid_reg <= grant_valid;
        if (grant_valid) begin
          fu_op_reg   <= sel_op;
          fu_vj_reg   <= sel_vj;
          fu_vk_reg   <= sel_vk;
          fu_imm_reg  <= sel_imm;
          fu_pc_reg   <= sel_pc;
          fu_dest_reg <= sel_dest;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_reg[i] && !rj_reg[i] && wj_hit[i]) begin
          rj_reg[i] <= 1'b1;
          vj_reg[i] <= wj_val[i];
        end
        if (busy_reg[i] && !rk_reg[i] && wk_hit[i]) begin
          rk_reg[i] <= 1'b1;
          vk_reg[i] <= wk_val[i];
        end
        if (disp_fire && grant[i]) busy_reg[i] <= 1'b0;
        // New entry is youngest: nothing is younger than it, every live entry is older.
        if (issue_fire && alloc_onehot[i]) begin
          busy_reg[i]  <= 1'b1;
          op_reg[i]    <= issue_op;
          qj_reg[i]    <= issue_qj;
          qk_reg[i]    <= issue_qk;
          rj_reg[i]    <= issue_rj | bj_hit;
          rk_reg[i]    <= issue_rk | bk_hit;
          vj_reg[i]    <= (!issue_rj && bj_hit) ? bj_val : issue_vj;
          vk_reg[i]    <= (!issue_rk && bk_hit) ? bk_val : issue_vk;
          imm_reg[i]   <= issue_imm;
          dest_reg[i]  <= issue_dest_rob;
          pc_reg[i]    <= issue_cur_pc;
          older_reg[i] <= '0;
        end else if (issue_fire && busy_reg[i]) begin
          older_reg[i] <= older_reg[i] | alloc_onehot;
        end
      end
    end
  end

  assign fu_valid    = fu_valid_reg;
  assign fu_op       = fu_op_reg;
  assign fu_vj       = fu_vj_reg;
  assign fu_vk       = fu_vk_reg;
  assign fu_imm      = fu_imm_reg;
  assign fu_cur_pc   = fu_pc_reg;
  assign fu_dest_rob = fu_dest_reg;
  assign occupancy   = occ_reg;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed self-checking bench for rs_multi_cdb (DEPTH=4, two broadcast channels).
module tb_rs_multi_cdb;
  import rs_multi_cdb_pkg::*;

  localparam int DEPTH   = 4;
  localparam int N_CDB   = 2;
  localparam int ROB_LOG = RS_ROB_LOG;
  localparam int OP_LOG  = RS_OP_LOG;
  localparam int XLEN    = RS_XLEN;

  logic clk = 1'b0;
  logic rst_n, rdy, flush, issue_valid, issue_ready;
  logic [OP_LOG-1:0] issue_op;
  logic [XLEN-1:0] issue_vj, issue_vk, issue_imm, issue_cur_pc;
  logic issue_rj, issue_rk;
  logic [ROB_LOG-1:0] issue_qj, issue_qk, issue_dest_rob;
  logic [N_CDB-1:0] cdb_valid;
  logic [N_CDB*ROB_LOG-1:0] cdb_rob;
  logic [N_CDB*XLEN-1:0] cdb_value;
  logic fu_valid, fu_ready;
  logic [OP_LOG-1:0] fu_op;
  logic [XLEN-1:0] fu_vj, fu_vk, fu_imm, fu_cur_pc;
  logic [ROB_LOG-1:0] fu_dest_rob;
  logic [$clog2(DEPTH):0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rs_multi_cdb #(.DEPTH(DEPTH), .N_CDB(N_CDB), .ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_imm(issue_imm),
    .issue_dest_rob(issue_dest_rob), .issue_cur_pc(issue_cur_pc),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op), .fu_vj(fu_vj), .fu_vk(fu_vk),
    .fu_imm(fu_imm), .fu_dest_rob(fu_dest_rob), .fu_cur_pc(fu_cur_pc), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue while full is illegal; broadcast channels must never carry the same tag together.
  always @(posedge clk) begin
    if (rst_n && rdy && !flush && issue_valid)
      check("issue_legal", {63'd0, issue_ready}, 64'd1);
    if (cdb_valid[0] && cdb_valid[1])
      check("cdb_unique", {63'd0, cdb_rob[ROB_LOG-1:0] != cdb_rob[2*ROB_LOG-1:ROB_LOG]}, 64'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [OP_LOG-1:0] op, input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                           input logic rj, input logic rk, input logic [ROB_LOG-1:0] qj,
                           input logic [ROB_LOG-1:0] qk, input logic [ROB_LOG-1:0] dest);
    issue_valid = 1'b1;
    issue_op = op;  issue_vj = vj;  issue_vk = vk;
    issue_rj = rj;  issue_rk = rk;  issue_qj = qj;  issue_qk = qk;
    issue_dest_rob = dest;
    issue_imm = vj ^ 32'h0000_ff00;
    issue_cur_pc = 32'h1000 + 32'(dest) * 4;
    $display("[TB] issue op=%0d vj=%0h vk=%0h rj=%0b rk=%0b qj=%0d qk=%0d dest=%0d",
             op, vj, vk, rj, rk, qj, qk, dest);
  endtask

  task automatic issue_step(input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk, input logic rj,
                            input logic [ROB_LOG-1:0] qj, input logic [ROB_LOG-1:0] dest);
    set_issue(OP_ADD, vj, vk, rj, 1'b1, qj, 4'd0, dest);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic set_cdb(input int ch, input logic [ROB_LOG-1:0] tag, input logic [XLEN-1:0] val);
    cdb_valid[ch] = 1'b1;
    cdb_rob[ch*ROB_LOG +: ROB_LOG] = tag;
    cdb_value[ch*XLEN +: XLEN] = val;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; fu_ready = 1'b1;
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0; issue_rj = 1'b0; issue_rk = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_imm = '0; issue_dest_rob = '0; issue_cur_pc = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_value = '0;

    // Reset and basic dispatch
    step(); step();
    check("rst_fu_valid", 64'(fu_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_fu_vj", 64'(fu_vj), 64'd0);
    rst_n = 1'b1;
    set_issue(OP_ADD, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0, 4'd3);
    step(); issue_valid = 1'b0;
    check("basic_occ1", 64'(occupancy), 64'd1);
    check("basic_not_yet", 64'(fu_valid), 64'd0);
    step();
    check("basic_fu_valid", 64'(fu_valid), 64'd1);
    check("basic_vj", 64'(fu_vj), 64'd5);
    check("basic_vk", 64'(fu_vk), 64'd7);
    check("basic_dest", 64'(fu_dest_rob), 64'd3);
    check("basic_op", 64'(fu_op), 64'(OP_ADD));
    check("basic_imm", 64'(fu_imm), 64'h0000_ff05);
    check("basic_pc", 64'(fu_cur_pc), 64'h100c);
    check("basic_occ0", 64'(occupancy), 64'd0);
    step();
    check("basic_drain", 64'(fu_valid), 64'd0);

    // Age ordering: A sits at a higher index than the younger B
    fu_ready = 1'b0;
    issue_step(32'd1, 32'd1, 1'b1, 4'd0, 4'd1);   // D -> entry0
    issue_step(32'd0, 32'd3, 1'b0, 4'd2, 4'd5);   // A -> entry1, D dispatched
    check("age_d_disp", 64'(fu_dest_rob), 64'd1);
    check("age_occ_a", 64'(occupancy), 64'd1);
    issue_step(32'd10, 32'd0, 1'b1, 4'd0, 4'd6);  // B -> entry0
    issue_step(32'd20, 32'd0, 1'b1, 4'd0, 4'd7);  // C -> entry2
    check("age_stall_dest", 64'(fu_dest_rob), 64'd1);
    check("age_occ3", 64'(occupancy), 64'd3);
    set_cdb(1, 4'd2, 32'd9);
    step(); cdb_valid = '0;
    check("age_stall2", 64'(fu_dest_rob), 64'd1);
    fu_ready = 1'b1;
    step();
    check("age_a_dest", 64'(fu_dest_rob), 64'd5);
    check("age_a_vj", 64'(fu_vj), 64'd9);
    check("age_a_vk", 64'(fu_vk), 64'd3);
    step();
    check("age_b_dest", 64'(fu_dest_rob), 64'd6);
    check("age_b_vj", 64'(fu_vj), 64'd10);
    step();
    check("age_c_dest", 64'(fu_dest_rob), 64'd7);
    check("age_c_occ", 64'(occupancy), 64'd0);
    step();
    check("age_drain", 64'(fu_valid), 64'd0);

    // Issue-cycle bypass from both channels
    set_issue(OP_XOR, 32'd0, 32'd0, 1'b0, 1'b0, 4'd4, 4'd6, 4'd8);
    set_cdb(0, 4'd4, 32'h11);
    set_cdb(1, 4'd6, 32'h22);
    step(); issue_valid = 1'b0; cdb_valid = '0;
    step();
    check("byp_valid", 64'(fu_valid), 64'd1);
    check("byp_vj", 64'(fu_vj), 64'h11);
    check("byp_vk", 64'(fu_vk), 64'h22);
    check("byp_dest", 64'(fu_dest_rob), 64'd8);
    check("byp_op", 64'(fu_op), 64'(OP_XOR));
    step();

    // Backpressure and full
    fu_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      issue_step(32'd100 + 32'(k), 32'd0, 1'b1, 4'd0, 4'(10 + k));
    check("full_occ_dm1", 64'(occupancy), 64'(DEPTH - 1));
    check("full_fu_hold", 64'(fu_vj), 64'd100);
    check("full_ready_hi", 64'(issue_ready), 64'd1);
    issue_step(32'd104, 32'd0, 1'b1, 4'd0, 4'd14);
    check("full_occ", 64'(occupancy), 64'(DEPTH));
    check("full_ready_lo", 64'(issue_ready), 64'd0);
    check("full_fu_dest", 64'(fu_dest_rob), 64'd10);
    fu_ready = 1'b1;
    step(); fu_ready = 1'b0;
    check("bp_one_disp", 64'(fu_dest_rob), 64'd11);
    check("bp_occ", 64'(occupancy), 64'(DEPTH - 1));
    check("bp_ready", 64'(issue_ready), 64'd1);
    step();
    check("bp_hold_dest", 64'(fu_dest_rob), 64'd11);
    check("bp_hold_occ", 64'(occupancy), 64'(DEPTH - 1));

    // Flush with a concurrent issue
    flush = 1'b1;
    set_issue(OP_SUB, 32'd77, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd15);
    step(); flush = 1'b0; issue_valid = 1'b0; fu_ready = 1'b1;
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_fu_valid", 64'(fu_valid), 64'd0);
    step();
    check("flush_drop_occ", 64'(occupancy), 64'd0);
    check("flush_drop_fu", 64'(fu_valid), 64'd0);

    // rdy freeze during a broadcast with an eligible entry
    issue_step(32'd0, 32'd5, 1'b0, 4'd7, 4'd2);     // G -> entry0, waits on tag 7
    issue_step(32'h33, 32'd0, 1'b1, 4'd0, 4'd9);    // F -> entry1, ready
    rdy = 1'b0;
    set_cdb(0, 4'd7, 32'h44);
    for (int k = 0; k < 3; k++) begin
      step();
      check("frz_fu_valid", 64'(fu_valid), 64'd0);
      check("frz_occ", 64'(occupancy), 64'd2);
    end
    cdb_valid = '0; rdy = 1'b1;
    step();
    check("frz_f_dest", 64'(fu_dest_rob), 64'd9);
    check("frz_f_vj", 64'(fu_vj), 64'h33);
    check("frz_f_occ", 64'(occupancy), 64'd1);
    step();
    check("frz_no_retro", 64'(fu_valid), 64'd0);
    set_cdb(1, 4'd7, 32'h55);
    step(); cdb_valid = '0;
    step();
    check("frz_g_valid", 64'(fu_valid), 64'd1);
    check("frz_g_vj", 64'(fu_vj), 64'h55);
    check("frz_g_dest", 64'(fu_dest_rob), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
